// File: rtl/mmio_port_bank_if.sv
// CPU-side bus of the port bank: address/direction/write data from the 6502,
// registered read data and the combinational window decode back to the top.
interface mmio_port_bank_if;
  logic [15:0] address;
  logic        read_write;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        chip_select;

  modport master (
    output address, read_write, data_in,
    input  data_out, chip_select
  );

  modport slave (
    input  address, read_write, data_in,
    output data_out, chip_select
  );
endinterface

// File: rtl/mmio_port_bank.sv
// NUM_PORTS bidirectional 8-bit ports in a 16-byte window: OR/DDR/IFR/IER per port,
// three-stage input synchronisers, rising-edge flags, write strobes, 1-cycle read latency.
module mmio_port_bank #(
  parameter logic [15:0] BASE_ADDR = 16'hFFF0,
  parameter int          NUM_PORTS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_port_bank_if.slave        bus,
  input  logic [8*NUM_PORTS-1:0] port_in,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic [8*NUM_PORTS-1:0] port_dir,
  output logic [NUM_PORTS-1:0]   port_strobe,
  output logic                   irq
);
  logic [7:0]           r_or  [NUM_PORTS];
  logic [7:0]           r_ddr [NUM_PORTS];
  logic [7:0]           r_ifr [NUM_PORTS];
  logic [7:0]           r_ier [NUM_PORTS];
  logic [7:0]           r_s1  [NUM_PORTS];
  logic [7:0]           r_s2  [NUM_PORTS];
  logic [7:0]           r_s3  [NUM_PORTS];
  logic [7:0]           r_data_out;
  logic [NUM_PORTS-1:0] r_strobe;
  logic                 r_irq;

  logic       w_cs;
  logic       w_we;
  logic [1:0] w_port;
  logic [1:0] w_reg;
  logic [7:0] w_rd_dat;
  logic       w_irq_any;

  assign w_cs   = (bus.address[15:4] == BASE_ADDR[15:4]);
  assign w_we   = w_cs & bus.read_write;
  assign w_port = bus.address[3:2];
  assign w_reg  = bus.address[1:0];

  assign bus.chip_select = w_cs;
  assign bus.data_out    = r_data_out;
  assign port_strobe     = r_strobe;
  assign irq             = r_irq;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pack
    assign port_out[8*g +: 8] = r_or[g];
    assign port_dir[8*g +: 8] = r_ddr[g];
  end

  // Offsets beyond the last implemented port match no p and fall through as 8'h00.
  always_comb begin
    w_rd_dat  = 8'h00;
    w_irq_any = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_irq_any = w_irq_any | (|(r_ifr[p] & r_ier[p]));
      if (w_port == 2'(p)) begin
        case (w_reg)
          2'd0:    w_rd_dat = (r_or[p] & r_ddr[p]) | (r_s2[p] & ~r_ddr[p]);
          2'd1:    w_rd_dat = r_ddr[p];
          2'd2:    w_rd_dat = r_ifr[p];
          default: w_rd_dat = r_ier[p];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_or[p]  <= 8'h00;
        r_ddr[p] <= 8'h00;
        r_ifr[p] <= 8'h00;
        r_ier[p] <= 8'h00;
        r_s1[p]  <= 8'h00;
        r_s2[p]  <= 8'h00;
        r_s3[p]  <= 8'h00;
      end
      r_data_out <= 8'h00;
      r_strobe   <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_data_out <= w_cs ? w_rd_dat : 8'h00;
      r_irq      <= w_irq_any;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_s1[p]     <= port_in[8*p +: 8];
        r_s2[p]     <= r_s1[p];
        r_s3[p]     <= r_s2[p];
        r_strobe[p] <= w_we && (w_port == 2'(p)) && (w_reg == 2'd0);
        if (w_we && (w_port == 2'(p))) begin
          case (w_reg)
            2'd0:    r_or[p]  <= bus.data_in;
            2'd1:    r_ddr[p] <= bus.data_in;
            2'd3:    r_ier[p] <= bus.data_in;
            default: ;
          endcase
        end
        // A new edge is OR-ed in after the write-1-clear, so set wins a collision.
        r_ifr[p] <= (r_ifr[p] &
                     ~((w_we && (w_port == 2'(p)) && (w_reg == 2'd2)) ? bus.data_in : 8'h00))
                    | (r_s2[p] & ~r_s3[p] & ~r_ddr[p]);
      end
    end
  end
endmodule

// File: doc/mmio_port_bank.md
# mmio_port_bank

Parametrised memory-mapped I/O port bank for the cpu6502 bus. It replaces the fixed write-only output latches at hard-coded addresses with NUM_PORTS bidirectional 8-bit ports. Each port has an output register, a data-direction register, synchronised input read-back, rising-edge interrupt flags with an enable mask, and a write strobe. It sits beside the RAM on the CPU address/data bus and drives board peripherals: LCD, hex displays and switches.

## Interface
Parameters:
- BASE_ADDR, 16'hFFF0: base of the 16-byte register window; must be 16-byte aligned.
- NUM_PORTS, 2: number of 8-bit ports, legal range 1..4.

Ports:
- clk, in, 1: system clock; all state updates on posedge.
- reset, in, 1: synchronous, active-high reset.
- address, in, 16: CPU address_out.
- read_write, in, 1: 1 = write cycle, 0 = read cycle.
- data_in, in, 8: CPU data_out (write data).
- data_out, out, 8: registered read data.
- chip_select, out, 1: combinational; high when address[15:4] == BASE_ADDR[15:4]. The top uses it to mux data_out against RAM.
- port_in, in, 8*NUM_PORTS: asynchronous pin inputs; port p occupies bits [8p+7:8p].
- port_out, out, 8*NUM_PORTS: output register values.
- port_dir, out, 8*NUM_PORTS: DDR values; 1 = bit driven as output.
- port_strobe, out, NUM_PORTS: one-cycle pulse per ORx write.
- irq, out, 1: registered interrupt request, active high.

## Operation
- Register map, offset = address[3:0], port p = offset[3:2]:
  - 4p+0: ORp, output register.
  - 4p+1: DDRp.
  - 4p+2: IFRp, edge flags; writing 1 to a bit clears it.
  - 4p+3: IERp, interrupt enable mask.
- Offsets ≥ 4*NUM_PORTS: read 8'h00; writes are ignored.
- Addresses outside the window: no state change; data_out registers 8'h00.
- Write: on the posedge where chip_select && read_write, the addressed register takes data_in. IFR takes IFR & ~data_in.
- Input path, per port: three-stage register chain s1 ← port_in, s2 ← s1, s3 ← s2.
- Read of ORp returns (ORp & DDRp) | (s2 & ~DDRp). Reads of DDR, IFR and IER return the raw register. Reads have no side effects.
- Edge detect: rise = s2 & ~s3 & ~DDRp. IFRp |= rise every cycle.
- Simultaneous set and write-1-clear on the same IFR bit: set wins, and the bit stays 1.
- irq ← |(IFRp & IERp) over all ports, registered.
- port_strobe[p] ← 1 for exactly one cycle after any write to ORp, including a write of an unchanged value. Otherwise 0.
- Reset: OR, DDR, IFR, IER, s1–s3, data_out, port_strobe and irq are all 0. port_out = 0 and port_dir = 0, so all bits are inputs. Reset overrides any write in the same cycle.

## Timing
- Write at posedge k: port_out / port_dir / IER visible after k. port_strobe is high from k to k+1.
- Read: address presented in cycle k-1 → data_out valid after posedge k, with 1-cycle latency matching synchronous RAM. data_out updates every cycle.
- Input change stable before posedge k: s2 = new value after k+1, so readable via data_out after k+2. IFR bit set at k+2; irq high after k+3.
- Clearing IFR at posedge k drops irq after k+1, provided no other enabled flag is set.
- Changing DDR bit from 1→0 re-exposes s2; no spurious edge, because s2/s3 are tracked regardless of DDR.
- Back-to-back writes to ORp on consecutive cycles: port_strobe stays high for both cycles, with no gap required.

## Test plan
- Reset: assert reset with port_in = 16'hFFFF. Every output reads 0, and reading 16'hFFF0 after release gives 16'hFF once synchronised.
- Output/DDR: write DDR0 = 8'hF0, then OR0 = 8'hA5, with port_in[7:0] = 8'h3C. port_out[7:0] = 8'hA5, port_strobe[0] pulses for 1 cycle, and a read of 16'hFFF0 returns 8'hAC.
- Edge interrupt: IER1 = 8'h01 at 16'hFFF7, then port_in[8] rises 0→1. IFR1 (16'hFFF6) reads 8'h01 and irq is high 3 cycles after the edge. Write 8'h01 to 16'hFFF6 and irq drops the next cycle.
- Set/clear collision: time the clear write so it lands on the same cycle as a new rising edge on that bit. IFR bit remains 1 and irq stays high.
- Decode: write 8'h55 to 16'hFFEF, 16'hFFF8 (unused with NUM_PORTS=2) and 16'h0000. No register changes, chip_select is low for 16'hFFEF and 16'h0000, and reads of 16'hFFF8 return 8'h00.
- Mid-operation reset: pulse reset while irq = 1 and OR0 = 8'hFF. On the next cycle irq = 0, port_out = 0 and port_strobe = 0.
